// File: rtl/stat_report_gen_if.sv
// Report stream towards the packet sink: registered data/valid strobes out,
// almost-full back-pressure in (gates packet start only).
interface stat_report_gen_if;
    logic [133:0] out_data;
    logic         out_data_wr;
    logic         out_data_valid;
    logic         out_data_valid_wr;
    logic         in_alm_full;

    modport master (
        output out_data, out_data_wr, out_data_valid, out_data_valid_wr,
        input  in_alm_full
    );

    modport slave (
        input  out_data, out_data_wr, out_data_valid, out_data_valid_wr,
        output in_alm_full
    );
endinterface

// File: rtl/stat_report_gen.sv
// Periodic / on-demand statistics report generator: snapshots TX/RX counters
// and streams them as one 134-bit-word packet with header, rows and tail.
//
// state | meaning
// IDLE  | waiting for pending report and free sink; emits MD0 on start
// MD1   | emit second metadata word
// ETH   | emit Ethernet header with seq and overrun snapshot
// TX    | emit TX counter rows, four channels per row
// RX    | emit RX counter rows, four channels per row
// TAIL  | emit tail word with packet-valid strobe, advance seq
module stat_report_gen #(
    parameter int          N_CH     = 8,
    parameter int          PERIOD   = 125_000_000,
    parameter logic [15:0] ETH_TYPE = 16'hff01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_test_start,
    input  logic                   in_report_req,
    input  logic [32*N_CH-1:0]     in_tx_cnt,
    input  logic [32*N_CH-1:0]     in_rx_cnt,
    input  logic [47:0]            timestamp,
    stat_report_gen_if.master      rpt
);
    localparam int R    = (N_CH + 3) / 4;
    localparam int L    = 4 + 2 * R;
    localparam int PADW = 128 * R;
    localparam int TW   = $clog2(PERIOD);
    localparam int RW   = (R > 1) ? $clog2(R) : 1;

    localparam logic [TW-1:0] T_LAST    = TW'(PERIOD - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(R - 1);
    localparam logic [11:0]   LEN_BYTES = 12'(16 * (L - 2));
    localparam logic [7:0]    NCH_BYTE  = 8'(N_CH);

    typedef enum logic [2:0] {IDLE, MD1, ETH, TX, RX, TAIL} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            tick;
    logic            evt;
    logic            start;
    logic            pending;
    logic [7:0]      ovr;
    logic [7:0]      ovr_snap;
    logic [7:0]      seq;
    logic [47:0]     ts_snap;
    logic [PADW-1:0] tx_snap;
    logic [PADW-1:0] rx_snap;
    logic [RW-1:0]   row;
    logic [127:0]    tx_row;
    logic [127:0]    rx_row;

    assign tick  = in_test_start && (timer == T_LAST);
    assign evt   = tick || in_report_req;
    assign start = (state == IDLE) && pending && !rpt.in_alm_full;

    // Snapshots are zero-padded to whole rows, so unused lanes read as zero.
    assign tx_row = tx_snap[row*128 +: 128];
    assign rx_row = rx_snap[row*128 +: 128];

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            pending <= 1'b0;
            ovr     <= 8'd0;
        end else begin
            if (!in_test_start || timer == T_LAST)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            // An event in the start cycle re-arms pending but is not an overrun.
            if (start)
                ovr <= 8'd0;
            else if (evt && pending && ovr != 8'hff)
                ovr <= ovr + 8'd1;

            if (evt)
                pending <= 1'b1;
            else if (start)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            row                   <= '0;
            seq                   <= 8'd0;
            ts_snap               <= 48'd0;
            ovr_snap              <= 8'd0;
            tx_snap               <= '0;
            rx_snap               <= '0;
            rpt.out_data          <= '0;
            rpt.out_data_wr       <= 1'b0;
            rpt.out_data_valid    <= 1'b0;
            rpt.out_data_valid_wr <= 1'b0;
        end else begin
            rpt.out_data          <= '0;
            rpt.out_data_wr       <= 1'b0;
            rpt.out_data_valid    <= 1'b0;
            rpt.out_data_valid_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ts_snap         <= timestamp;
                        ovr_snap        <= ovr;
                        tx_snap         <= PADW'(in_tx_cnt);
                        rx_snap         <= PADW'(in_rx_cnt);
                        rpt.out_data    <= {2'b01, 4'd0, 20'd0, LEN_BYTES, 48'd0, timestamp};
                        rpt.out_data_wr <= 1'b1;
                        state           <= MD1;
                    end
                end
                MD1: begin
                    rpt.out_data    <= {2'b11, 4'd0, 128'd0};
                    rpt.out_data_wr <= 1'b1;
                    state           <= ETH;
                end
                ETH: begin
                    rpt.out_data    <= {2'b11, 4'd0, 48'hffff_ffff_ffff, 48'h0, ETH_TYPE, seq, ovr_snap};
                    rpt.out_data_wr <= 1'b1;
                    row             <= '0;
                    state           <= TX;
                end
                TX: begin
                    rpt.out_data    <= {2'b11, 4'd0, tx_row};
                    rpt.out_data_wr <= 1'b1;
                    if (row == ROW_LAST) begin
                        row   <= '0;
                        state <= RX;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                RX: begin
                    rpt.out_data    <= {2'b11, 4'd0, rx_row};
                    rpt.out_data_wr <= 1'b1;
                    if (row == ROW_LAST) begin
                        row   <= '0;
                        state <= TAIL;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                TAIL: begin
                    rpt.out_data          <= {2'b10, 4'd0, 72'd0, NCH_BYTE, ts_snap};
                    rpt.out_data_wr       <= 1'b1;
                    rpt.out_data_valid    <= 1'b1;
                    rpt.out_data_valid_wr <= 1'b1;
                    seq                   <= seq + 8'd1;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stat_report_gen.sv
// Bench for stat_report_gen: two instances (8 and 5 channels) driven in lock-step
// and compared every cycle against a packet-queue reference model.
module tb_stat_report_gen;
    localparam int PERIOD = 20;
    localparam int L      = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         test_start;
    logic         report_req;
    logic         alm_full;
    logic [255:0] tx_cnt;
    logic [255:0] rx_cnt;
    logic [47:0]  timestamp;

    always #5 clk = ~clk;

    stat_report_gen_if bus8();
    stat_report_gen_if bus5();
    assign bus8.in_alm_full = alm_full;
    assign bus5.in_alm_full = alm_full;

    stat_report_gen #(.N_CH(8), .PERIOD(PERIOD), .ETH_TYPE(16'hff01)) dut8 (
        .clk(clk), .rst(rst), .in_test_start(test_start), .in_report_req(report_req),
        .in_tx_cnt(tx_cnt), .in_rx_cnt(rx_cnt), .timestamp(timestamp), .rpt(bus8)
    );

    stat_report_gen #(.N_CH(5), .PERIOD(PERIOD), .ETH_TYPE(16'hff01)) dut5 (
        .clk(clk), .rst(rst), .in_test_start(test_start), .in_report_req(report_req),
        .in_tx_cnt(tx_cnt[159:0]), .in_rx_cnt(rx_cnt[159:0]), .timestamp(timestamp), .rpt(bus5)
    );

    typedef struct {
        logic [47:0]  ts;
        logic [255:0] tx;
        logic [255:0] rx;
        logic [7:0]   seq;
        logic [7:0]   ovr;
    } snap_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    int    m_timer;
    bit    m_pend;
    int    m_ovr;
    int    m_seq;
    int    mq[$];
    int    exp_idx;
    snap_t cur;

    // observation helpers (dut8 stream, dut5 captured alongside)
    int           ncyc, first_wr, tail_cyc, wr_cnt, tails, pos, guard, tails0;
    logic [7:0]   eth_seq, eth_ovr;
    logic [133:0] cap8[0:7];
    logic [133:0] cap5[0:7];

    function automatic logic [133:0] exp_word(int nch, int idx, snap_t s);
        int r;
        int k;
        int rr;
        int ch;
        logic [127:0] rowv;
        r = (nch + 3) / 4;
        if (idx < 0) return '0;
        if (idx == 0) return {2'b01, 4'd0, 20'd0, 12'(16 * (2 + 2 * r)), 48'd0, s.ts};
        if (idx == 1) return {2'b11, 4'd0, 128'd0};
        if (idx == 2) return {2'b11, 4'd0, 48'hffff_ffff_ffff, 48'h0, 16'hff01, s.seq, s.ovr};
        if (idx == 3 + 2 * r) return {2'b10, 4'd0, 72'd0, 8'(nch), s.ts};
        k    = idx - 3;
        rr   = k % r;
        rowv = '0;
        for (int lane = 0; lane < 4; lane++) begin
            ch = 4 * rr + lane;
            if (ch < nch) rowv[32*lane +: 32] = (k >= r) ? s.rx[32*ch +: 32] : s.tx[32*ch +: 32];
        end
        return {2'b11, 4'd0, rowv};
    endfunction

    task automatic check(input string tag, input logic [136:0] obs, input logic [136:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit tick, ev, go;
        if (rst) begin
            m_timer = 0; m_pend = 0; m_ovr = 0; m_seq = 0;
            mq.delete();
            exp_idx = -1;
            return;
        end
        tick = test_start && (m_timer == PERIOD - 1);
        ev   = tick || report_req;
        go   = (mq.size() == 0) && m_pend && !alm_full;
        if (go) begin
            cur.ts  = timestamp;
            cur.tx  = tx_cnt;
            cur.rx  = rx_cnt;
            cur.seq = 8'(m_seq);
            cur.ovr = 8'(m_ovr);
            exp_idx = 0;
            for (int i = 1; i < L; i++) mq.push_back(i);
        end else if (mq.size() > 0) begin
            exp_idx = mq.pop_front();
            if (exp_idx == L - 1) m_seq = (m_seq + 1) % 256;
        end else begin
            exp_idx = -1;
        end
        if (go) m_ovr = 0;
        else if (ev && m_pend && m_ovr < 255) m_ovr++;
        if (ev) m_pend = 1;
        else if (go) m_pend = 0;
        m_timer = (test_start && m_timer != PERIOD - 1) ? m_timer + 1 : 0;
    endtask

    task automatic tick_cycle();
        logic [2:0] fl;
        model_step();
        @(negedge clk);
        ncyc++;
        fl = {exp_idx >= 0, exp_idx == L - 1, exp_idx == L - 1};
        check("dut8_data", bus8.out_data, exp_word(8, exp_idx, cur));
        check("dut8_flags", {bus8.out_data_wr, bus8.out_data_valid, bus8.out_data_valid_wr}, fl);
        check("dut5_data", bus5.out_data, exp_word(5, exp_idx, cur));
        check("dut5_flags", {bus5.out_data_wr, bus5.out_data_valid, bus5.out_data_valid_wr}, fl);
        if (rst) begin
            pos = 0;
        end else if (bus8.out_data_wr) begin
            if (first_wr < 0) first_wr = ncyc;
            wr_cnt++;
            if (pos < 8) begin
                cap8[pos] = bus8.out_data;
                cap5[pos] = bus5.out_data;
            end
            if (pos == 2) begin
                eth_seq = bus8.out_data[15:8];
                eth_ovr = bus8.out_data[7:0];
            end
            pos++;
            if (bus8.out_data_valid) begin
                tails++;
                tail_cyc = ncyc;
                pos = 0;
            end
        end
        timestamp = timestamp + 48'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick_cycle();
        rst = 1'b0;
    endtask

    task automatic pulse_req_and_run(input int n);
        report_req = 1'b1;
        tick_cycle();
        report_req = 1'b0;
        repeat (n) tick_cycle();
    endtask

    initial begin
        rst = 1'b1; test_start = 1'b0; report_req = 1'b0; alm_full = 1'b0;
        tx_cnt = '0; rx_cnt = '0; timestamp = 48'h0000_0000_1000;
        m_timer = 0; m_pend = 0; m_ovr = 0; m_seq = 0; exp_idx = -1;
        ncyc = 0; first_wr = -1; tail_cyc = -1; wr_cnt = 0; tails = 0; pos = 0;
        eth_seq = '0; eth_ovr = '0;
        repeat (3) tick_cycle();
        check("reset_data", bus8.out_data, 134'd0);

        // periodic report, channel i = i+1 / 0x100+i
        for (int i = 0; i < 8; i++) begin
            tx_cnt[32*i +: 32] = 32'(i + 1);
            rx_cnt[32*i +: 32] = 32'h100 + 32'(i);
        end
        rst = 1'b0; test_start = 1'b1;
        ncyc = 0; first_wr = -1; wr_cnt = 0;
        repeat (30) tick_cycle();
        test_start = 1'b0;
        check("md0_cycle", first_wr, 21);
        check("tail_cycle", tail_cyc, 28);
        check("wr_count", wr_cnt, 8);
        check("md0_len", cap8[0][107:96], 12'd96);
        check("eth_seq0", cap8[2][15:8], 8'd0);
        check("tx_row0", cap8[3], {2'b11, 4'd0, 32'd4, 32'd3, 32'd2, 32'd1});
        check("tx_row1", cap8[4], {2'b11, 4'd0, 32'd8, 32'd7, 32'd6, 32'd5});
        check("rx_row0", cap8[5], {2'b11, 4'd0, 32'h103, 32'h102, 32'h101, 32'h100});
        check("rx_row1", cap8[6], {2'b11, 4'd0, 32'h107, 32'h106, 32'h105, 32'h104});
        check("n5_len", cap5[0][107:96], 12'd96);
        check("n5_tx_row1", cap5[4], {2'b11, 4'd0, 96'd0, 32'd5});
        check("n5_tail_nch", cap5[7][55:48], 8'd5);

        // back-pressure over two ticks
        do_reset();
        test_start = 1'b1; alm_full = 1'b1; wr_cnt = 0;
        repeat (45) tick_cycle();
        check("alm_no_output", wr_cnt, 0);
        test_start = 1'b0; alm_full = 1'b0;
        repeat (15) tick_cycle();
        check("alm_ovr1", eth_ovr, 8'd1);
        pulse_req_and_run(14);
        check("alm_ovr_next", eth_ovr, 8'd0);
        check("alm_seq_next", eth_seq, 8'd1);

        // request coincident with tick
        do_reset();
        test_start = 1'b1;
        repeat (19) tick_cycle();
        report_req = 1'b1;
        tick_cycle();
        report_req = 1'b0; test_start = 1'b0;
        tails0 = tails;
        repeat (20) tick_cycle();
        check("coincident_one_pkt", tails - tails0, 1);
        check("coincident_ovr0", eth_ovr, 8'd0);

        // overrun saturation
        do_reset();
        alm_full = 1'b1; report_req = 1'b1;
        repeat (300) tick_cycle();
        alm_full = 1'b0; report_req = 1'b0;
        repeat (12) tick_cycle();
        check("ovr_saturate", eth_ovr, 8'd255);

        // sequence wrap over 256 packets
        do_reset();
        for (int p = 0; p < 256; p++) pulse_req_and_run(9);
        check("seq_255", eth_seq, 8'd255);
        pulse_req_and_run(9);
        check("seq_wrap", eth_seq, 8'd0);

        // reset during second RX row
        report_req = 1'b1;
        tick_cycle();
        report_req = 1'b0;
        guard = 0;
        while (pos != 7 && guard < 30) begin
            tick_cycle();
            guard++;
        end
        check("reach_rx1", pos, 7);
        tails0 = tails;
        rst = 1'b1;
        tick_cycle();
        check("abort_wr", bus8.out_data_wr, 1'b0);
        check("abort_data", bus8.out_data, 134'd0);
        rst = 1'b0;
        repeat (10) tick_cycle();
        check("abort_no_tail", tails, tails0);
        pulse_req_and_run(12);
        check("abort_seq0", eth_seq, 8'd0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            test_start = ($urandom_range(0, 9) != 0);
            report_req = ($urandom_range(0, 11) == 0);
            alm_full   = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++) begin
                tx_cnt[32*i +: 32] = $urandom;
                rx_cnt[32*i +: 32] = $urandom;
            end
            tick_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
